ks_sub16_pipe: RTL and testbench

Pipelined 16-bit Kogge-Stone subtractor computing D = A − B as A + ~B + 1. It is the subtract-direction counterpart of the Kogge-Stone adder datapath and reuses the same P/G prefix structure: one preprocess stage, four prefix layers (spans 1, 2, 4, 8) and a sum stage. Each stage is registered behind a valid/ready handshake. The block sits between operand producers and ALU result consumers and sustains one subtraction per clock when not back-pressured.

---
 rtl/ks_sub16_pipe.sv | 128 ++++++++++++
 tb/tb_ks_sub16_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sub16_pipe.sv
// Purpose: 16-bit Kogge-Stone subtractor D = A - B (as A + ~B + 1) with a
//          registered valid/ready handshake on every pipeline stage.
// Latency: 5 register stages; operands captured at one edge have OUT_VALID
//          high after the fifth edge, counting the capturing edge. One result per clock.
// Backpressure: global stall (OUT_VALID & ~OUT_READY) freezes all stages;
//               IN_READY = ~stall is a deliberate combinational path.
// Ports: CLK, RST_N (async active-low); A, B, IN_VALID, IN_READY operand side;
//        D, BOUT, OUT_VALID, OUT_READY result side; V, Z only when
//        KS_SUB16_FLAGS_EN is defined (signed overflow, zero flag).
module ks_sub16_pipe (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [15:0] D,
  output logic        BOUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY
`ifdef KS_SUB16_FLAGS_EN
  ,
  output logic        V,
  output logic        Z
`endif
);

  // Prefix node, generate half: G'[i] = G[i] | P[i] & G[i-s] for i >= s.
  function automatic logic [15:0] pfx_g(input logic [15:0] p, input logic [15:0] g,
                                         input int s);
    logic [15:0] r;
    r = g;
    for (int i = s; i < 16; i++) r[i] = g[i] | (p[i] & g[i-s]);
    return r;
  endfunction

  // Prefix node, propagate half: P'[i] = P[i] & P[i-s] for i >= s.
  function automatic logic [15:0] pfx_p(input logic [15:0] p, input int s);
    logic [15:0] r;
    r = p;
    for (int i = s; i < 16; i++) r[i] = p[i] & p[i-s];
    return r;
  endfunction

  logic        stall;
  logic        adv;
  logic [15:0] bn, pre_p, pre_g;

  logic        v0, v1, v2, v3;
  logic [15:0] p0_0, p_0, g_0;
  logic [15:0] p0_1, p_1, g_1;
  logic [15:0] p0_2, p_2, g_2;
  logic [15:0] p0_3, p_3, g_3;

  logic [15:0] gf;
  logic [15:0] d_nxt;

  assign stall    = OUT_VALID & ~OUT_READY;
  assign adv      = ~stall;
  assign IN_READY = ~stall;

  // Preprocess; the +1 carry-in is folded into bit 0 of generate.
  always_comb begin
    bn       = ~B;
    pre_p    = A ^ bn;
    pre_g    = A & bn;
    pre_g[0] = pre_g[0] | pre_p[0];
  end

  // Last prefix layer (span 8) and sum. Gf[i-1] is the carry into bit i,
  // so bit 0 sees the folded carry-in of 1, i.e. D[0] = ~P0[0].
  always_comb begin
    gf    = pfx_g(p_3, g_3, 8);
    d_nxt = p0_3 ^ {gf[14:0], 1'b1};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      p0_0 <= '0; p_0 <= '0; g_0 <= '0;
      p0_1 <= '0; p_1 <= '0; g_1 <= '0;
      p0_2 <= '0; p_2 <= '0; g_2 <= '0;
      p0_3 <= '0; p_3 <= '0; g_3 <= '0;
    end else if (adv) begin
      // A low IN_VALID enters as a bubble; bubbles are never collapsed.
      v0   <= IN_VALID;
      p0_0 <= pre_p;
      p_0  <= pre_p;
      g_0  <= pre_g;

      v1   <= v0;
      p0_1 <= p0_0;
      p_1  <= pfx_p(p_0, 1);
      g_1  <= pfx_g(p_0, g_0, 1);

      v2   <= v1;
      p0_2 <= p0_1;
      p_2  <= pfx_p(p_1, 2);
      g_2  <= pfx_g(p_1, g_1, 2);

      v3   <= v2;
      p0_3 <= p0_2;
      p_3  <= pfx_p(p_2, 4);
      g_3  <= pfx_g(p_2, g_2, 4);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      D         <= '0;
      BOUT      <= 1'b0;
`ifdef KS_SUB16_FLAGS_EN
      V         <= 1'b0;
      Z         <= 1'b0;
`endif
    end else if (adv) begin
      OUT_VALID <= v3;
      D         <= d_nxt;
      BOUT      <= ~gf[15];
`ifdef KS_SUB16_FLAGS_EN
      V         <= gf[15] ^ gf[14];
      Z         <= (d_nxt == 16'h0000);
`endif
    end
  end

endmodule

// File: tb/tb_ks_sub16_pipe.sv
// Bench for ks_sub16_pipe: directed vectors with hand-computed differences,
// a scoreboard queue filled by the driver and drained by a negedge monitor.
module tb_ks_sub16_pipe;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bout;
  } vec_t;

  logic        CLK;
  logic        RST_N;
  logic [15:0] A, B;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] D;
  logic        BOUT;
  logic        OUT_VALID;
  logic        OUT_READY;
`ifdef KS_SUB16_FLAGS_EN
  logic        V, Z;
`endif

  ks_sub16_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D(D), .BOUT(BOUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef KS_SUB16_FLAGS_EN
    , .V(V), .Z(Z)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   n_stall = 0;
  exp_t exp_q[$];
  int   out_cyc[$];
  logic        hold_vld = 1'b0;
  logic [15:0] hold_d = '0;

  // Hand-computed streams: {A, B, A-B mod 2^16, A<B}.
  vec_t stream[8] = '{
    '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0},
    '{16'h0001, 16'hFFFF, 16'h0002, 1'b1},
    '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1},
    '{16'h8000, 16'h7FFF, 16'h0001, 1'b0},
    '{16'hABCD, 16'h1234, 16'h9999, 1'b0},
    '{16'h1234, 16'hABCD, 16'h6667, 1'b1},
    '{16'h00FF, 16'h0F00, 16'hF1FF, 1'b1},
    '{16'hC350, 16'h2710, 16'h9C40, 1'b0}
  };

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops and compares on every output transfer, checks stall behaviour.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("in_ready", {31'd0, IN_READY}, {31'd0, !(OUT_VALID && !OUT_READY)});
      if (OUT_VALID && !OUT_READY) begin
        n_stall++;
        if (hold_vld) chk("hold_d", {16'd0, D}, {16'd0, hold_d});
        hold_vld = 1'b1;
        hold_d   = D;
      end else begin
        hold_vld = 1'b0;
      end
      if (OUT_VALID && OUT_READY) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {16'd0, D}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("d", {16'd0, D}, {16'd0, e.d});
          chk("bout", {31'd0, BOUT}, {31'd0, e.bout});
`ifdef KS_SUB16_FLAGS_EN
          chk("v", {31'd0, V}, {31'd0, e.v});
          chk("z", {31'd0, Z}, {31'd0, e.z});
`endif
        end
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  // Call at posedge+1. Holds the pair until it is accepted, then drops IN_VALID.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] d, input logic bo);
    bit   acc = 1'b0;
    exp_t e;
    e.d    = d;
    e.bout = bo;
    e.v    = (a[15] ^ b[15]) & (d[15] ^ a[15]);
    e.z    = (d == 16'h0000);
    A = a; B = b; IN_VALID = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge CLK);
      acc = IN_READY;
      if (acc) exp_q.push_back(e);
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    if (!acc) chk("send_accept", 32'd0, 32'd1);
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 60 && exp_q.size() > 0; t++) @(posedge CLK);
    #1;
    chk(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b0; A = '0; B = '0;
    #1;
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_d", {16'd0, D}, 32'd0);
    chk("rst_bout", {31'd0, BOUT}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // First result and its latency: captured at edge 1, visible after edge 5.
    send(16'h0005, 16'h0003, 16'h0002, 1'b0);
    repeat (3) @(posedge CLK);
    #1 chk("lat_early", {31'd0, OUT_VALID}, 32'd0);
    @(posedge CLK);
    #1 chk("lat_on", {31'd0, OUT_VALID}, 32'd1);
    chk("lat_d", {16'd0, D}, 32'h0002);
    drain("drain_first");

    // Corner pairs: borrow, signed overflow, zero result.
    send(16'h0000, 16'h0001, 16'hFFFF, 1'b1);
    send(16'h8000, 16'h0001, 16'h7FFF, 1'b0);
    send(16'h1234, 16'h1234, 16'h0000, 1'b0);
    drain("drain_corner");

    // Back-to-back stream: eight results on consecutive cycles.
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send(stream[i].a, stream[i].b, stream[i].d, stream[i].bout);
    drain("drain_stream");
    chk("stream_count", out_cyc.size(), 32'd8);
    for (int i = 1; i < 8 && i < out_cyc.size(); i++)
      chk("stream_gap", out_cyc[i] - out_cyc[i-1], 32'd1);

    // Same stream with OUT_READY low for three cycles mid-stream.
    n_out = 0;
    n_stall = 0;
    fork
      for (int i = 0; i < 8; i++) send(stream[i].a, stream[i].b, stream[i].d, stream[i].bout);
      begin
        repeat (7) @(posedge CLK);
        #1 OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
    join
    drain("drain_stall");
    chk("stall_count", n_out, 32'd8);
    chk("stall_cycles", n_stall, 32'd3);

    // Bubbles: valid pattern 1,0,1,0,1 comes out with the same gaps.
    out_cyc.delete();
    send(16'h0100, 16'h0001, 16'h00FF, 1'b0);
    idle();
    send(16'h0001, 16'h0100, 16'hFF01, 1'b1);
    idle();
    send(16'hF000, 16'h0F00, 16'hE100, 1'b0);
    drain("drain_bubble");
    chk("bubble_count", out_cyc.size(), 32'd3);
    for (int i = 1; i < 3 && i < out_cyc.size(); i++)
      chk("bubble_gap", out_cyc[i] - out_cyc[i-1], 32'd2);

    // Reset with results in flight: first result stalled at the output.
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) send(stream[i].a, stream[i].b, stream[i].d, stream[i].bout);
    @(posedge CLK);
    #1 chk("pre_rst_valid", {31'd0, OUT_VALID}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("midrst_d", {16'd0, D}, 32'd0);
    chk("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
    exp_q.delete();
    @(posedge CLK);
    #1 RST_N = 1'b1;
    OUT_READY = 1'b1;
    n_out = 0;
    send(16'h0005, 16'h0003, 16'h0002, 1'b0);
    drain("drain_post_rst");
    repeat (8) @(posedge CLK);
    #1 chk("post_rst_count", n_out, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
